gain_vector: RTL and testbench

- Computes the RLS gain vector k = P·a / (lambda + aᵀ·P·a) for one update step.
- Sits directly upstream of the state-update stage and supplies its k input.
- Signed fixed point, Q(WIDTH-FRAC).FRAC.
- Work is sequential: a COMBSIZE-lane MAC array for the matrix/vector phases, then one shared sequential divider for the normalisation.

---
 rtl/gain_vector_pkg.sv | 45 ++++
 rtl/gain_vector_if.sv | 19 +
 rtl/gain_vector_fixed_div.sv | 94 +++++++++
 rtl/gain_vector.sv | 165 ++++++++++++++++
 tb/tb_gain_vector.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gain_vector_pkg.sv
// Shared definitions for the RLS gain-vector datapath: Q-format constants,
// the shift-and-saturate helper and the controller state encoding.
package gain_vector_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefFrac  = 16;
  localparam int unsigned DefSize  = 16;
  localparam int unsigned DefComb  = 4;

  localparam logic signed [DefWidth-1:0] One    = 32'sh0001_0000;
  localparam logic signed [DefWidth-1:0] MaxVal = 32'sh7FFF_FFFF;
  localparam logic signed [DefWidth-1:0] MinVal = 32'sh8000_0000;

  // Wide enough for any accumulator this family uses; callers truncate the result.
  localparam int unsigned MaxAccW = 128;
  localparam int unsigned MaxW    = 64;

  typedef logic signed [MaxAccW-1:0] acc_t;

  typedef enum logic [2:0] {
    StIdle,
    StMatvec,
    StDot,
    StDiv,
    StDone
  } state_e;

  // Arithmetic shift right by frac, then clamp to a signed width-bit range.
  function automatic logic signed [MaxW-1:0] sat_shift(acc_t acc, int unsigned frac,
                                                       int unsigned width);
    acc_t sh;
    acc_t hi;
    acc_t lo;
    sh = acc >>> frac;
    hi = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (width - 1));
    if (sh > hi) begin
      sh = hi;
    end else if (sh < lo) begin
      sh = lo;
    end
    return sh[MaxW-1:0];
  endfunction

endpackage

// File: rtl/gain_vector_if.sv
// Request/result bundle between the gain-vector stage and its producer/consumer.
interface gain_vector_if
  import gain_vector_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SIZE  = DefSize
);
  logic                         start;
  logic [WIDTH*SIZE*SIZE-1:0]   p;
  logic [WIDTH*SIZE-1:0]        a;
  logic [WIDTH-1:0]             lambda;
  logic [WIDTH*SIZE-1:0]        k;
  logic                         busy;
  logic                         done;
  logic                         div_zero;

  modport master (output start, p, a, lambda, input k, busy, done, div_zero);
  modport slave  (input start, p, a, lambda, output k, busy, done, div_zero);
endinterface

// File: rtl/gain_vector_fixed_div.sv
// Sequential restoring divider: quo = (num << FRAC) / den on magnitudes, signed,
// saturating; one load cycle plus WIDTH+FRAC iterations, done_o during the last.
module fixed_div
  import gain_vector_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned FRAC  = DefFrac
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic signed [WIDTH-1:0] num_i,
  input  logic signed [WIDTH-1:0] den_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic signed [WIDTH-1:0] quo_o
);
  localparam int unsigned DvdW = WIDTH + FRAC;
  localparam int unsigned CntW = $clog2(DvdW);
  localparam logic signed [WIDTH-1:0] MinV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MaxV = {1'b0, {(WIDTH-1){1'b1}}};

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [DvdW-1:0] dvd_q;
  logic [DvdW-2:0] quo_q;
  logic [WIDTH-1:0] den_q, rem_q;
  logic neg_q, num_neg_q, num_zero_q, den_zero_q;

  logic [WIDTH-1:0] num_abs, den_abs, rem_diff, rem_next, mag;
  logic [WIDTH:0]   rem_sh;
  logic [DvdW-1:0]  quo_next;
  logic             fits, ovf;

  always_comb begin
    num_abs  = num_i[WIDTH-1] ? -num_i : num_i;
    den_abs  = den_i[WIDTH-1] ? -den_i : den_i;
    rem_sh   = {rem_q, dvd_q[DvdW-1]};
    fits     = (rem_sh >= {1'b0, den_q});
    rem_diff = rem_sh[WIDTH-1:0] - den_q;
    rem_next = fits ? rem_diff : rem_sh[WIDTH-1:0];
    quo_next = {quo_q, fits};
    ovf      = |quo_next[DvdW-1:WIDTH-1];
    mag      = {1'b0, quo_next[WIDTH-2:0]};
    // Zero denominator: result depends only on the numerator sign.
    if (den_zero_q) begin
      quo_o = num_zero_q ? '0 : (num_neg_q ? MinV : MaxV);
    end else if (ovf) begin
      quo_o = neg_q ? MinV : MaxV;
    end else begin
      quo_o = neg_q ? -mag : mag;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CntW'(DvdW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      num_neg_q  <= 1'b0;
      num_zero_q <= 1'b0;
      den_zero_q <= 1'b0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q     <= 1'b1;
        cnt_q      <= '0;
        rem_q      <= '0;
        quo_q      <= '0;
        dvd_q      <= {num_abs, {FRAC{1'b0}}};
        den_q      <= den_abs;
        neg_q      <= num_i[WIDTH-1] ^ den_i[WIDTH-1];
        num_neg_q  <= num_i[WIDTH-1];
        num_zero_q <= (num_i == '0);
        den_zero_q <= (den_i == '0);
      end
    end else begin
      rem_q <= rem_next;
      quo_q <= quo_next[DvdW-2:0];
      dvd_q <= dvd_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gain_vector.sv
// RLS gain vector k = P*a / (lambda + a'*P*a): COMBSIZE-lane MAC for the
// matrix/vector and dot phases, then one shared divider per element.
module gain_vector
  import gain_vector_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned FRAC     = DefFrac,
  parameter int unsigned SIZE     = DefSize,
  parameter int unsigned COMBSIZE = DefComb
) (
  input logic          clk,
  input logic          rst_n,
  gain_vector_if.slave bus
);
  localparam int unsigned NChunk = SIZE / COMBSIZE;
  localparam int unsigned AccW   = 2 * WIDTH + $clog2(SIZE);
  localparam int unsigned IdxW   = $clog2(SIZE * SIZE);
  localparam int unsigned ElW    = $clog2(SIZE);
  localparam int unsigned ChW    = (NChunk > 1) ? $clog2(NChunk) : 1;

  state_e state_q, state_d;
  logic signed [WIDTH-1:0] p_q [SIZE*SIZE];
  logic signed [WIDTH-1:0] a_q [SIZE];
  logic signed [WIDTH-1:0] u_q [SIZE];
  logic signed [WIDTH-1:0] shadow_q [SIZE];
  logic signed [WIDTH-1:0] k_q [SIZE];
  logic signed [WIDTH-1:0] lambda_q, d_q;
  logic signed [AccW-1:0]  acc_q;
  logic [ElW-1:0]          row_q, el_q;
  logic [ChW-1:0]          chunk_q;
  logic                    done_q, dz_q;

  logic [ElW-1:0]            col_idx [COMBSIZE];
  logic signed [WIDTH-1:0]   mul_x [COMBSIZE];
  logic signed [WIDTH-1:0]   mul_y [COMBSIZE];
  logic signed [2*WIDTH-1:0] prod [COMBSIZE];
  logic signed [AccW-1:0]    mac_sum, acc_sum;
  logic signed [WIDTH-1:0]   mac_res, lam_sum, div_quo;
  logic                      chunk_last, div_start, div_busy, div_done;
  logic [WIDTH*SIZE-1:0]     k_flat;

  // MATVEC multiplies P(row,c)*a_c; DOT reuses the same lanes for a_i*u_i.
  always_comb begin
    mac_sum = '0;
    for (int l = 0; l < COMBSIZE; l++) begin
      col_idx[l] = ElW'(chunk_q * COMBSIZE + l);
      if (state_q == StMatvec) begin
        mul_x[l] = p_q[IdxW'(row_q * SIZE + col_idx[l])];
        mul_y[l] = a_q[col_idx[l]];
      end else begin
        mul_x[l] = a_q[col_idx[l]];
        mul_y[l] = u_q[col_idx[l]];
      end
      prod[l] = mul_x[l] * mul_y[l];
      mac_sum = mac_sum + AccW'(prod[l]);
    end
    acc_sum    = acc_q + mac_sum;
    mac_res    = WIDTH'(sat_shift(MaxAccW'(acc_sum), FRAC, WIDTH));
    lam_sum    = WIDTH'(sat_shift(MaxAccW'(lambda_q) + MaxAccW'(mac_res), 0, WIDTH));
    chunk_last = (chunk_q == ChW'(NChunk - 1));
  end

  assign div_start = (state_q == StDiv) && !div_busy;

  fixed_div #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   (u_q[el_q]),
    .den_i   (d_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StMatvec;
      StMatvec: if (chunk_last && row_q == ElW'(SIZE - 1)) state_d = StDot;
      StDot:    if (chunk_last) state_d = StDiv;
      StDiv:    if (div_done && el_q == ElW'(SIZE - 1)) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      row_q    <= '0;
      el_q     <= '0;
      chunk_q  <= '0;
      lambda_q <= '0;
      d_q      <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      for (int i = 0; i < SIZE * SIZE; i++) p_q[i] <= '0;
      for (int i = 0; i < SIZE; i++) begin
        a_q[i]      <= '0;
        u_q[i]      <= '0;
        shadow_q[i] <= '0;
        k_q[i]      <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            for (int i = 0; i < SIZE * SIZE; i++) p_q[i] <= bus.p[WIDTH*i +: WIDTH];
            for (int i = 0; i < SIZE; i++) a_q[i] <= bus.a[WIDTH*i +: WIDTH];
            lambda_q <= bus.lambda;
            acc_q    <= '0;
            row_q    <= '0;
            chunk_q  <= '0;
            el_q     <= '0;
          end
        end
        StMatvec, StDot: begin
          if (chunk_last) begin
            if (state_q == StMatvec) begin
              u_q[row_q] <= mac_res;
              row_q      <= row_q + 1'b1;
            end else begin
              d_q <= lam_sum;
            end
            acc_q   <= '0;
            chunk_q <= '0;
          end else begin
            acc_q   <= acc_sum;
            chunk_q <= chunk_q + 1'b1;
          end
        end
        StDiv: begin
          if (div_done) begin
            shadow_q[el_q] <= div_quo;
            el_q           <= el_q + 1'b1;
          end
        end
        StDone: begin
          k_q    <= shadow_q;
          done_q <= 1'b1;
          dz_q   <= (d_q == '0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    k_flat = '0;
    for (int i = 0; i < SIZE; i++) k_flat[WIDTH*i +: WIDTH] = k_q[i];
  end

  assign bus.k        = k_flat;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_gain_vector.sv
// Directed-vector bench for gain_vector: identity covariance with hand-computed gains,
// zero denominator, ignored start while busy, back-to-back start and mid-run reset.
module tb_gain_vector;
  import gain_vector_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned F   = 16;
  localparam int unsigned N   = 16;
  localparam int unsigned C   = 4;
  localparam int          Lat = 1 + N * N / C + N / C + N * (W + F + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gain_vector_if #(.WIDTH(W), .SIZE(N)) bus_if ();

  gain_vector #(
    .WIDTH    (W),
    .FRAC     (F),
    .SIZE     (N),
    .COMBSIZE (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic logic [W-1:0] kel(input int i);
    return bus_if.k[W*i +: W];
  endfunction

  // P = identity; a_0 = a0, other a_i = arest.
  task automatic load_inputs(input logic [W-1:0] a0, input logic [W-1:0] arest,
                             input logic [W-1:0] lam);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) bus_if.p[W*(r*N+c) +: W] = (r == c) ? One : '0;
    end
    bus_if.a[0 +: W] = a0;
    for (int i = 1; i < N; i++) bus_if.a[W*i +: W] = arest;
    bus_if.lambda = lam;
  endtask

  task automatic kick();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
    n_cmp++; if (bus_if.div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero: got %b want 0", bus_if.div_zero); end
    n_cmp++; if (bus_if.k !== '0) begin n_err++; $display("FAIL reset_k: got %h want 0", bus_if.k); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int cyc;
    load_inputs(One, One, One);
    kick();
    wait_done(cyc);
    n_cmp++; if (cyc !== Lat) begin n_err++; $display("FAIL identity_latency: got %0d want %0d", cyc, Lat); end
    n_cmp++; if (bus_if.div_zero !== 1'b0) begin n_err++; $display("FAIL identity_div_zero: got %b want 0", bus_if.div_zero); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (kel(i) !== 32'h0000_0F0F) begin n_err++; $display("FAIL identity_k%0d: got %h want 00000f0f", i, kel(i)); end
    end
    @(posedge clk);
    #1;
    n_cmp++; if (bus_if.done !== 1'b0) begin n_err++; $display("FAIL done_single_pulse: got %b want 0", bus_if.done); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done: got %b want 0", bus_if.busy); end
  endtask

  task automatic test_unit_e0();
    int cyc;
    load_inputs(One, '0, One);
    kick();
    wait_done(cyc);
    n_cmp++; if (kel(0) !== 32'h0000_8000) begin n_err++; $display("FAIL e0_k0: got %h want 00008000", kel(0)); end
    for (int i = 1; i < N; i++) begin
      n_cmp++;
      if (kel(i) !== '0) begin n_err++; $display("FAIL e0_k%0d: got %h want 0", i, kel(i)); end
    end
  endtask

  task automatic test_negative();
    int cyc;
    load_inputs(32'hFFFF_0000, '0, 32'h0003_0000);
    kick();
    wait_done(cyc);
    n_cmp++; if (kel(0) !== 32'hFFFF_C000) begin n_err++; $display("FAIL neg_k0: got %h want ffffc000", kel(0)); end
    n_cmp++; if (kel(5) !== '0) begin n_err++; $display("FAIL neg_k5: got %h want 0", kel(5)); end
  endtask

  task automatic test_div_zero();
    int cyc;
    load_inputs(One, '0, 32'hFFFF_0000);
    kick();
    wait_done(cyc);
    n_cmp++; if (cyc !== Lat) begin n_err++; $display("FAIL dz_latency: got %0d want %0d", cyc, Lat); end
    n_cmp++; if (kel(0) !== MaxVal) begin n_err++; $display("FAIL dz_k0: got %h want 7fffffff", kel(0)); end
    n_cmp++; if (kel(1) !== '0) begin n_err++; $display("FAIL dz_k1: got %h want 0", kel(1)); end
    n_cmp++; if (bus_if.div_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", bus_if.div_zero); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    cyc = 0;
    load_inputs(One, One, One);
    kick();
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (i == 50) begin
        n_cmp++;
        if (kel(0) !== MaxVal) begin n_err++; $display("FAIL k_held_midrun: got %h want 7fffffff", kel(0)); end
      end
      if (i == 100) begin
        load_inputs(One, '0, One);
        bus_if.start = 1'b1;
      end
      if (i == 101) begin
        bus_if.start = 1'b0;
        n_cmp++;
        if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL busy_after_ignored_start: got %b want 1", bus_if.busy); end
      end
      if (bus_if.done) begin
        cyc = i;
        break;
      end
    end
    n_cmp++; if (cyc !== Lat) begin n_err++; $display("FAIL jobA_latency: got %0d want %0d", cyc, Lat); end
    n_cmp++; if (bus_if.div_zero !== 1'b0) begin n_err++; $display("FAIL jobA_div_zero: got %b want 0", bus_if.div_zero); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (kel(i) !== 32'h0000_0F0F) begin n_err++; $display("FAIL jobA_k%0d: got %h want 00000f0f", i, kel(i)); end
    end
    // Job B inputs are still on the bus; restart in the done cycle.
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    wait_done(cyc);
    n_cmp++; if (cyc !== Lat) begin n_err++; $display("FAIL jobB_latency: got %0d want %0d", cyc, Lat); end
    n_cmp++; if (kel(0) !== 32'h0000_8000) begin n_err++; $display("FAIL jobB_k0: got %h want 00008000", kel(0)); end
    n_cmp++; if (kel(1) !== '0) begin n_err++; $display("FAIL jobB_k1: got %h want 0", kel(1)); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int n_done;
    n_done = 0;
    load_inputs(32'hFFFF_0000, '0, 32'h0003_0000);
    kick();
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_if.k !== '0) begin n_err++; $display("FAIL midreset_k: got %h want 0", bus_if.k); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", bus_if.done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d pulses want 0", n_done); end
    kick();
    wait_done(cyc);
    n_cmp++; if (cyc !== Lat) begin n_err++; $display("FAIL postreset_latency: got %0d want %0d", cyc, Lat); end
    n_cmp++; if (kel(0) !== 32'hFFFF_C000) begin n_err++; $display("FAIL postreset_k0: got %h want ffffc000", kel(0)); end
  endtask

  initial begin
    bus_if.start  = 1'b0;
    bus_if.p      = '0;
    bus_if.a      = '0;
    bus_if.lambda = '0;
    test_reset();
    test_identity();
    test_unit_e0();
    test_negative();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
